rd_capture_align: RTL and testbench
===================================

Name: rd_capture_align

Overview:
- Receive-side counterpart to the command delay line in the memory controller.
- Tracks each issued read command through a latency pipeline and samples returning memory data dq_in exactly lat cycles after issue.
- Pushes the sampled data into a small FIFO that drains to the controller core over a valid/ready handshake.
- Sits between the PHY data input and the controller's read-data return path.

Parameters:
- W, 4, data width of dq_in and q_data.
- MAX_LAT, 8, maximum supported read latency in clk cycles; number of issue-pipeline stages.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- lat  input  4  programmed read latency; quasi-static, changed only while busy=0.
- issue  input  1  one-cycle pulse per read command issued to memory.
- dq_in  input  W  returning memory read data.
- q_data  output  W  FIFO head data.
- q_valid  output  1  FIFO non-empty.
- q_ready  input  1  consumer accepts head when q_valid&&q_ready.
- busy  output  1  any read in flight in the issue pipeline.
- overflow  output  1  sticky; a capture was dropped because the FIFO was full.

Behaviour:
- Reset (async, rst=1): issue pipeline cleared, FIFO pointers and count 0, q_valid=0, q_data=0, busy=0, overflow=0. Any in-flight captures are discarded; no push occurs after reset releases.
- Effective latency L: lat clamped to 1..MAX_LAT (0 -> 1, >MAX_LAT -> MAX_LAT).
- Issue pipeline: stage[1] <= issue; stage[k] <= stage[k-1] for k=2..MAX_LAT. cap = stage[L] (combinational tap).
- Timing:
  - issue high in cycle t -> cap high in cycle t+L.
  - dq_in present in cycle t+L is written on that cycle's closing edge.
  - q_valid=1 and q_data=that word from cycle t+L+1 (if the FIFO was empty).
- Back-to-back issues (every cycle) produce back-to-back captures in order.
- busy = issue | OR of all stage bits (combinational).
- FIFO behaviour:
  - Circular buffer, registered storage; q_data = mem[rd_ptr].
  - q_valid = (count != 0).
  - Pointers wrap modulo depth.
- Push = cap. Pop = q_valid && q_ready.
- Push and pop in the same cycle: count unchanged, both pointers advance. This holds when full (push accepted because a slot frees) and when count=1.
- Push when full without pop: data dropped, pointers unchanged, overflow <= 1 and held until rst.
- Pop when empty: impossible by definition (q_valid=0); q_ready ignored.
- count width FIFO_AW+1; full when count = 2**FIFO_AW.

Optional Feature:
- Macro: RD_CAPTURE_AL_CAL_EN.
- When defined, adds ports: cal_start input 1, cal_pattern input W, cal_done output 1, cal_err output 1, cal_lat output 4.
- FSM states IDLE, COUNT:
  - IDLE + cal_start -> COUNT, counter <= 1, cal_done <= 0, cal_err <= 0.
  - COUNT, dq_in == cal_pattern -> IDLE, cal_lat <= counter, cal_done <= 1.
  - COUNT, no match and counter == MAX_LAT -> IDLE, cal_err <= 1, cal_lat <= 0.
  - Otherwise counter++.
- cal_start is pulsed in the same cycle as the training issue. A match on the first COUNT cycle therefore gives cal_lat=1.
- While cal_done=1, L = cal_lat and the lat input is ignored.
- All calibration outputs reset to 0.
- When not defined: ports absent, L derived from lat only.

Test Plan:
- lat=3, issue at cycle 10, dq_in=4'h5 only in cycle 13 -> q_valid rises cycle 14, q_data=4'h5; q_ready=1 pops it, q_valid=0 cycle 15.
- lat=2, issue cycles 0..5 continuous, dq_in=cycle number, q_ready=0 -> FIFO holds 2,3,4,5; captures at cycles 6,7 dropped; overflow=1 stays set; drain yields 2,3,4,5 in order.
- FIFO full, q_ready=1 in capture cycle -> push accepted, no overflow, count stays 4.
- lat=0 and lat=12 -> behave as L=1 and L=8 respectively (capture 1 and 8 cycles after issue).
- rst asserted 1 cycle after issue with lat=4 -> after release, no push ever; q_valid=0, busy=0, overflow=0.
- RD_CAPTURE_AL_CAL_EN, cal_pattern=4'hA:
  - cal_start at cycle 20, dq_in=4'hA at cycle 25 -> cal_done=1, cal_lat=5; subsequent reads captured 5 cycles after issue regardless of lat.
  - No match -> cal_err=1, cal_lat=0.

Source files
------------

// File: rtl/rd_capture_align.sv
// Read-data capture: delays each issued read by the effective latency, samples dq_in then,
// and queues the word in a small FIFO. Optional latency training under RD_CAPTURE_AL_CAL_EN.
module rd_capture_align #(
    parameter int unsigned W       = 4,
    parameter int unsigned MAX_LAT = 8,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   lat,
    input  logic         issue,
    input  logic [W-1:0] dq_in,
    output logic [W-1:0] q_data,
    output logic         q_valid,
    input  logic         q_ready,
    output logic         busy,
`ifdef RD_CAPTURE_AL_CAL_EN
    input  logic         cal_start,
    input  logic [W-1:0] cal_pattern,
    output logic         cal_done,
    output logic         cal_err,
    output logic [3:0]   cal_lat,
`endif
    output logic         overflow
);

    localparam int unsigned LAT_W = 4;
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;

    logic [LAT_W-1:0]   lat_src_c;
    logic [LAT_W-1:0]   lat_eff_c;
    logic [MAX_LAT:1]   stage_q;
    logic               cap_c;

    logic [W-1:0]       mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               valid_c, full_c, pop_c, push_ok_c;

`ifdef RD_CAPTURE_AL_CAL_EN
    typedef enum logic {
        CAL_IDLE,
        CAL_COUNT
    } cal_state_e;

    cal_state_e       cal_state_q, cal_state_d;
    logic [LAT_W-1:0] cal_cnt_q, cal_cnt_d;
    logic [LAT_W-1:0] cal_lat_q, cal_lat_d;
    logic             cal_done_q, cal_done_d;
    logic             cal_err_q, cal_err_d;

    // Training measures cycles from cal_start until the pattern appears on dq_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cal_state_q <= CAL_IDLE;
            cal_cnt_q   <= '0;
            cal_lat_q   <= '0;
            cal_done_q  <= 1'b0;
            cal_err_q   <= 1'b0;
        end else begin
            cal_state_q <= cal_state_d;
            cal_cnt_q   <= cal_cnt_d;
            cal_lat_q   <= cal_lat_d;
            cal_done_q  <= cal_done_d;
            cal_err_q   <= cal_err_d;
        end
    end

    always_comb begin
        cal_state_d = cal_state_q;
        cal_cnt_d   = cal_cnt_q;
        cal_lat_d   = cal_lat_q;
        cal_done_d  = cal_done_q;
        cal_err_d   = cal_err_q;
        case (cal_state_q)
            CAL_IDLE: begin
                if (cal_start) begin
                    cal_state_d = CAL_COUNT;
                    cal_cnt_d   = LAT_W'(1);
                    cal_done_d  = 1'b0;
                    cal_err_d   = 1'b0;
                end
            end
            CAL_COUNT: begin
                if (dq_in == cal_pattern) begin
                    cal_state_d = CAL_IDLE;
                    cal_lat_d   = cal_cnt_q;
                    cal_done_d  = 1'b1;
                end else if (32'(cal_cnt_q) == MAX_LAT) begin
                    cal_state_d = CAL_IDLE;
                    cal_lat_d   = '0;
                    cal_err_d   = 1'b1;
                end else begin
                    cal_cnt_d = cal_cnt_q + LAT_W'(1);
                end
            end
            default: cal_state_d = CAL_IDLE;
        endcase
    end

    assign cal_done = cal_done_q;
    assign cal_err  = cal_err_q;
    assign cal_lat  = cal_lat_q;
`endif

    // Effective latency: trained value wins once calibration succeeded, then clamp to 1..MAX_LAT.
    always_comb begin
        lat_src_c = lat;
`ifdef RD_CAPTURE_AL_CAL_EN
        if (cal_done_q) begin
            lat_src_c = cal_lat_q;
        end
`endif
        if (lat_src_c == '0) begin
            lat_eff_c = LAT_W'(1);
        end else if (32'(lat_src_c) > MAX_LAT) begin
            lat_eff_c = LAT_W'(MAX_LAT);
        end else begin
            lat_eff_c = lat_src_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[MAX_LAT-1:1], issue};
        end
    end

    always_comb begin
        cap_c = 1'b0;
        for (int unsigned k = 1; k <= MAX_LAT; k++) begin
            if (lat_eff_c == LAT_W'(k)) begin
                cap_c = stage_q[k];
            end
        end
    end

    assign busy = issue | (|stage_q);

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign valid_c   = (count_q != '0);
    assign full_c    = (count_q == CNT_W'(DEPTH));
    assign pop_c     = valid_c && q_ready;
    assign push_ok_c = cap_c && (!full_c || pop_c);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        if (push_ok_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok_c && pop_c) begin
            count_d = count_q - CNT_W'(1);
        end
        if (cap_c && !push_ok_c) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push_ok_c) begin
                mem_q[wr_ptr_q] <= dq_in;
            end
        end
    end

    assign q_data   = mem_q[rd_ptr_q];
    assign q_valid  = valid_c;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_rd_capture_align.sv
// Directed bench for rd_capture_align; calibration cases build when RD_CAPTURE_AL_CAL_EN is defined.
module tb_rd_capture_align;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   lat = 4'd0;
    logic         issue = 1'b0;
    logic [W-1:0] dq_in = '0;
    logic [W-1:0] q_data;
    logic         q_valid;
    logic         q_ready = 1'b0;
    logic         busy;
    logic         overflow;
`ifdef RD_CAPTURE_AL_CAL_EN
    logic         cal_start = 1'b0;
    logic [W-1:0] cal_pattern = 4'hA;
    logic         cal_done;
    logic         cal_err;
    logic [3:0]   cal_lat;
`endif

    int n_checks = 0;
    int n_errors = 0;

    rd_capture_align #(.W(4), .MAX_LAT(8), .FIFO_AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .lat        (lat),
        .issue      (issue),
        .dq_in      (dq_in),
        .q_data     (q_data),
        .q_valid    (q_valid),
        .q_ready    (q_ready),
        .busy       (busy),
`ifdef RD_CAPTURE_AL_CAL_EN
        .cal_start  (cal_start),
        .cal_pattern(cal_pattern),
        .cal_done   (cal_done),
        .cal_err    (cal_err),
        .cal_lat    (cal_lat),
`endif
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle; inputs set after this belong to that cycle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; issue = 1'b0; q_ready = 1'b0; dq_in = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic flush();
        issue = 1'b0;
        q_ready = 1'b1;
        repeat (16) tick();
        q_ready = 1'b0;
    endtask

    // Issue in cycle 0 with dq_in = cycle number; capture must hold exp_l and appear at exp_l+1.
    task automatic lat_test(input logic [3:0] l, input int exp_l, input string tag);
        lat = l; issue = 1'b1; dq_in = '0;
        for (int c = 1; c <= exp_l + 1; c++) begin
            tick();
            issue = 1'b0;
            dq_in = W'(c);
            if (c == exp_l) check({tag, "_early"}, 32'(q_valid), 32'd0);
        end
        check({tag, "_valid"}, 32'(q_valid), 32'd1);
        check({tag, "_data"}, 32'(q_data), 32'(exp_l));
        q_ready = 1'b1;
        tick();
        q_ready = 1'b0;
        check({tag, "_pop"}, 32'(q_valid), 32'd0);
        flush();
    endtask

    task automatic drain(input int first, input int n, input string tag);
        for (int e = first; e < first + n; e++) begin
            check({tag, "_dv"}, 32'(q_valid), 32'd1);
            check({tag, "_dd"}, 32'(q_data), 32'(e));
            q_ready = 1'b1;
            tick();
        end
        q_ready = 1'b0;
        check({tag, "_empty"}, 32'(q_valid), 32'd0);
    endtask

    initial begin
        #1;
        check("rst_valid", 32'(q_valid), 32'd0);
        check("rst_data", 32'(q_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
`ifdef RD_CAPTURE_AL_CAL_EN
        check("rst_cal_done", 32'(cal_done), 32'd0);
        check("rst_cal_err", 32'(cal_err), 32'd0);
        check("rst_cal_lat", 32'(cal_lat), 32'd0);
`endif
        do_reset();

        // Nominal and clamped latencies
        lat_test(4'd3, 3, "lat3");
        lat_test(4'd0, 1, "lat0");
        lat_test(4'd12, 8, "lat12");
        lat_test(4'd8, 8, "lat8");

        // Overflow: six back-to-back reads into a 4-deep FIFO with no consumer
        lat = 4'd2; q_ready = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            issue = (c <= 5);
            dq_in = W'(c);
            if (c == 0) begin
                #1;
                check("ovf_busy", 32'(busy), 32'd1);
            end
            tick();
        end
        issue = 1'b0;
        check("ovf_flag", 32'(overflow), 32'd1);
        drain(2, 4, "ovf");
        check("ovf_sticky", 32'(overflow), 32'd1);
        repeat (4) tick();
        check("ovf_idle_busy", 32'(busy), 32'd0);
        do_reset();
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO with a pop in the capture cycle
        lat = 4'd1;
        for (int c = 0; c <= 5; c++) begin
            issue = (c <= 4);
            dq_in = W'(c);
            q_ready = (c == 5);
            tick();
        end
        issue = 1'b0; q_ready = 1'b0;
        check("full_pop_ovf", 32'(overflow), 32'd0);
        drain(2, 4, "full_pop");
        flush();

        // Reset while a read is in flight
        lat = 4'd4; issue = 1'b1; dq_in = 4'h7;
        tick();
        issue = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        dq_in = 4'hF;
        repeat (10) tick();
        check("midrst_valid", 32'(q_valid), 32'd0);
        check("midrst_busy2", 32'(busy), 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);

`ifdef RD_CAPTURE_AL_CAL_EN
        // Training pattern arrives five cycles after cal_start
        do_reset();
        lat = 4'd2; cal_pattern = 4'hA;
        cal_start = 1'b1; issue = 1'b1; dq_in = '0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            cal_start = 1'b0; issue = 1'b0;
            dq_in = (c == 5) ? 4'hA : 4'h0;
        end
        check("cal_done", 32'(cal_done), 32'd1);
        check("cal_lat", 32'(cal_lat), 32'd5);
        check("cal_err0", 32'(cal_err), 32'd0);
        flush();
        lat_test(4'd1, 5, "cal_l5");

        // No match within MAX_LAT cycles
        cal_start = 1'b1; dq_in = 4'h3;
        tick();
        cal_start = 1'b0;
        repeat (10) tick();
        check("calerr_err", 32'(cal_err), 32'd1);
        check("calerr_lat", 32'(cal_lat), 32'd0);
        check("calerr_done", 32'(cal_done), 32'd0);
        lat_test(4'd2, 2, "calerr_l2");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
